// File: rtl/alu_shift_seq.sv
// Multi-bit shift sequencer: breaks an N-bit shift into N single-bit ops on the
// registered shift unit and returns the result over a valid/ready handshake.
module alu_shift_seq #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_dir,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [WIDTH-1:0]   in_a,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               busy,
    output logic [3:0]         sh_opcode,
    output logic [WIDTH-1:0]   sh_a,
    input  logic [WIDTH-1:0]   sh_out
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int CMP_W = (SHAMT_W > CNT_W) ? SHAMT_W : CNT_W;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_SLL = 4'b0110;
    localparam logic [3:0] OP_SRA = 4'b0111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Shifting past WIDTH is idempotent, so the amount saturates at WIDTH.
    function automatic logic [CNT_W-1:0] clamp_amt(input logic [SHAMT_W-1:0] shamt);
        logic [CMP_W-1:0] wide;
        wide = CMP_W'(shamt);
        if (wide > CMP_W'(WIDTH)) begin
            clamp_amt = CNT_W'(WIDTH);
        end else begin
            clamp_amt = CNT_W'(wide);
        end
    endfunction

    function automatic logic [3:0] shift_op(input logic dir);
        shift_op = dir ? OP_SRA : OP_SLL;
    endfunction

    state_t             state_r;
    logic               dir_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [WIDTH-1:0]   work_r;
    logic [WIDTH-1:0]   out_data_r;
    logic [WIDTH-1:0]   sh_a_r;
    logic [3:0]         sh_opcode_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic               busy_r;
    logic [CNT_W-1:0]   amt_s;

    assign amt_s = clamp_amt(in_shamt);

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            dir_r       <= 1'b0;
            cnt_r       <= '0;
            work_r      <= '0;
            out_data_r  <= '0;
            sh_a_r      <= '0;
            sh_opcode_r <= OP_NOP;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        dir_r      <= in_dir;
                        cnt_r      <= amt_s;
                        work_r     <= in_a;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        if (amt_s == '0) begin
                            out_data_r  <= in_a;
                            out_valid_r <= 1'b1;
                            state_r     <= DONE;
                        end else begin
                            sh_a_r      <= in_a;
                            sh_opcode_r <= shift_op(in_dir);
                            state_r     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    sh_opcode_r <= OP_NOP;
                    state_r     <= CAPTURE;
                end
                CAPTURE: begin
                    // sh_out now holds the result of the op issued last cycle.
                    work_r <= sh_out;
                    cnt_r  <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        out_data_r  <= sh_out;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        sh_a_r      <= sh_out;
                        sh_opcode_r <= shift_op(dir_r);
                        state_r     <= ISSUE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    sh_opcode_r <= OP_NOP;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign sh_opcode = sh_opcode_r;
    assign sh_a      = sh_a_r;

endmodule

// File: tb/tb_alu_shift_seq.sv
// Directed bench for alu_shift_seq with a behavioural single-bit shift unit.
module tb_alu_shift_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_dir;
    logic [4:0]  in_shamt;
    logic [15:0] in_a;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        busy;
    logic [3:0]  sh_opcode;
    logic [15:0] sh_a;
    logic [15:0] sh_out;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_shift_seq #(.WIDTH(16), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_dir(in_dir),
        .in_shamt(in_shamt), .in_a(in_a),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .sh_opcode(sh_opcode), .sh_a(sh_a), .sh_out(sh_out)
    );

    // Reference single-bit shift unit: registered, synchronous reset, 0 on NOP.
    always @(posedge clk) begin
        if (!rst_n)                    sh_out <= 16'h0000;
        else if (sh_opcode == 4'b0110) sh_out <= {sh_a[14:0], 1'b0};
        else if (sh_opcode == 4'b0111) sh_out <= {sh_a[15], sh_a[15:1]};
        else                           sh_out <= 16'h0000;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] a, input logic dir, input logic [4:0] shamt);
        in_a     = a;
        in_dir   = dir;
        in_shamt = shamt;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Called in cycle 1 after the accept edge; runs until out_valid or a bound.
    task automatic wait_done(input string tag, input logic [15:0] exp_data, input int exp_lat,
                             input int exp_issues, input logic [3:0] exp_op);
        int cyc    = 1;
        int issues = 0;
        int bad    = 0;
        while (!out_valid && cyc < 200) begin
            if (sh_opcode === exp_op) issues++;
            else if (sh_opcode !== 4'b0000) bad++;
            step();
            cyc++;
        end
        check({tag, " out_valid"}, 32'(out_valid), 32'd1);
        check({tag, " latency"},   32'(cyc),       32'(exp_lat));
        check({tag, " issues"},    32'(issues),    32'(exp_issues));
        check({tag, " bad_op"},    32'(bad),       32'd0);
        check({tag, " data"},      32'(out_data),  32'(exp_data));
        check({tag, " in_ready"},  32'(in_ready),  32'd0);
        check({tag, " busy"},      32'(busy),      32'd1);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, " idle out_valid"}, 32'(out_valid), 32'd0);
        check({tag, " idle in_ready"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        int seen;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_dir    = 1'b0;
        in_shamt  = 5'd0;
        in_a      = 16'h0000;
        out_ready = 1'b0;
        step();
        step();
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst busy",      32'(busy),      32'd0);
        check("rst out_data",  32'(out_data),  32'd0);
        check("rst sh_a",      32'(sh_a),      32'd0);
        check("rst sh_opcode", 32'(sh_opcode), 32'd0);
        rst_n = 1'b1;
        step();

        start(16'h0003, 1'b0, 5'd4);
        wait_done("sll4", 16'h0030, 9, 4, 4'b0110);
        consume("sll4");

        start(16'h8000, 1'b1, 5'd3);
        wait_done("sra3", 16'hF000, 7, 3, 4'b0111);
        consume("sra3");

        start(16'h1234, 1'b0, 5'd0);
        wait_done("sh0", 16'h1234, 1, 0, 4'b0110);
        consume("sh0");

        start(16'h1234, 1'b0, 5'd31);
        wait_done("sll31", 16'h0000, 33, 16, 4'b0110);
        consume("sll31");

        start(16'h8001, 1'b1, 5'd31);
        wait_done("sra31", 16'hFFFF, 33, 16, 4'b0111);
        consume("sra31");

        // Backpressure: hold DONE while a second request waits on in_valid.
        start(16'h0005, 1'b0, 5'd1);
        wait_done("bp", 16'h000A, 3, 1, 4'b0110);
        in_a     = 16'h0001;
        in_dir   = 1'b0;
        in_shamt = 5'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp hold out_valid", 32'(out_valid), 32'd1);
            check("bp hold data",      32'(out_data),  32'h000A);
            check("bp hold in_ready",  32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready",  32'(in_ready),  32'd1);
        step();
        in_valid = 1'b0;
        check("bp second accepted", 32'(in_ready), 32'd0);
        wait_done("bp2", 16'h0004, 5, 2, 4'b0110);
        consume("bp2");

        // Reset during CAPTURE abandons the request.
        start(16'h0001, 1'b0, 5'd6);
        step();
        check("mid capture busy",   32'(busy),      32'd1);
        check("mid capture opcode", 32'(sh_opcode), 32'd0);
        check("mid capture sh_a",   32'(sh_a),      32'h0001);
        rst_n = 1'b0;
        #1;
        check("async in_ready",  32'(in_ready),  32'd1);
        check("async busy",      32'(busy),      32'd0);
        check("async out_valid", 32'(out_valid), 32'd0);
        check("async sh_a",      32'(sh_a),      32'd0);
        check("async sh_opcode", 32'(sh_opcode), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid) seen++;
        end
        check("abandoned no result", 32'(seen), 32'd0);

        start(16'h0001, 1'b0, 5'd2);
        wait_done("post_rst", 16'h0004, 5, 2, 4'b0110);
        consume("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
